image_stream_reader: RTL
========================

# image_stream_reader

Read-side counterpart to the IO address decoder. The decoder maps CPU stores onto the original image region (120..160119), the processed image region (160120..320119) and the show strobes (addresses 100 and 116). When a show strobe fires, this block reads one full image region back out of image memory, one pixel at a time, and streams the pixels to the display/UART path over a valid/ready handshake. A 2-entry skid FIFO covers the one-cycle memory read latency against downstream backpressure.

## Interface
- `ORIG_BASE`, default 120: first byte address of the original image.
- `PROC_BASE`, default 160120: first byte address of the processed image.
- `IMG_PIXELS`, default 160000: pixels per frame (400×400).
- `ADDR_W`, default 24: memory address width.
- `DATA_W`, default 8: pixel width.

Ports (name, direction, width, meaning):
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_original` in 1: one-cycle pulse driven by the address-100 show decode.
- `start_processed` in 1: one-cycle pulse driven by the address-116 show decode.
- `rd_en` out 1: memory read request.
- `rd_addr` out ADDR_W: read address, valid while `rd_en` is high.
- `rd_data` in DATA_W: read data, valid exactly 1 cycle after `rd_en`.
- `pix_data` out DATA_W: stream data.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: stream ready.
- `pix_last` out 1: marks the final pixel of the frame.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse after the last pixel handshake.

## Operation
- States:
  - IDLE: waits for a start pulse.
  - RUN: issues reads.
  - DRAIN: all reads are issued; waits for the FIFO and in-flight read to empty.
- IDLE → RUN on any start pulse.
  - Base address = `PROC_BASE` if `start_processed`, otherwise `ORIG_BASE`.
  - `start_processed` wins if both pulses are high in the same cycle.
  - Read index resets to 0.
- Start pulses are ignored outside IDLE. They are not queued.
- Read issue in RUN:
  - `rd_en` = 1 when (fifo_count + inflight − pop) < 2, where pop = `pix_valid & pix_ready`.
  - `rd_addr` = base + index. The index increments on each issue.
  - The address computation is ADDR_W-bit unsigned and never wraps for legal parameters.
- RUN → DRAIN in the cycle the read for index `IMG_PIXELS`−1 is issued.
- `inflight` is a 1-bit register set on issue. On the next cycle `rd_data` is pushed into the FIFO and `inflight` clears, unless another read is issued that cycle.
- FIFO:
  - Depth 2, first in, first out.
  - `pix_valid` = (fifo_count ≠ 0).
  - `pix_data` = head entry.
  - Push and pop in the same cycle are both honoured.
  - The credit rule guarantees no overflow.
- `pix_last` = `pix_valid` and the head entry is frame pixel `IMG_PIXELS`−1. Track this with a pop counter or a tagged last bit.
- Handshake:
  - `pix_data`, `pix_valid` and `pix_last` stay stable while `pix_valid & !pix_ready`.
  - Once asserted, `pix_valid` never drops without a handshake.
- DRAIN → IDLE on the handshake of the last pixel. `done` = 1 in the following cycle. `busy` falls in the same cycle as `done`.
- Reset, including mid-frame:
  - State returns to IDLE.
  - FIFO is emptied; `inflight` and index clear.
  - All outputs are 0: `rd_en`, `rd_addr`, `pix_valid`, `pix_data`, `pix_last`, `busy`, `done`.
  - `rd_data` returned in the cycle after reset is discarded.

## Timing
- Start high in cycle 0:
  - cycle 1: `busy` = 1, `rd_en` = 1, `rd_addr` = base.
  - cycle 2: `rd_data` arrives and is captured at the end of the cycle.
  - cycle 3: first `pix_valid`.
- With `pix_ready` held at 1, throughput is 1 pixel/cycle. A frame therefore takes `IMG_PIXELS` + 3 cycles from start to `done`.
- When `pix_ready` deasserts, reads stall once 2 entries are committed. No data is lost or duplicated.
- All outputs are registered except `rd_en`/`rd_addr` (from state and counters) and `pix_*` (from FIFO registers).

## Structure
- Shared `io_pkg`:
  - address-map constants (`ORIG_BASE`, `PROC_BASE`, `IMG_PIXELS`, the show addresses 100 and 116);
  - the state enum (IDLE, RUN, DRAIN).
- One sub-module: `skid_fifo2`, a parameterised DATA_W+1-bit 2-entry FIFO. The extra bit carries the last tag.
- FSM, counters and credit logic live in the top module.

## Test plan
Run with `IMG_PIXELS`=4, `ORIG_BASE`=120, `PROC_BASE`=200, and memory preloaded with mem[a] = a[7:0].
- `start_original` pulse, `pix_ready`=1:
  - reads issued at 120, 121, 122, 123;
  - pixels 120..123 output on consecutive cycles, first in cycle 3;
  - `pix_last` on 123;
  - `done` one cycle after the 123 handshake.
- `start_original` and `start_processed` in the same cycle → stream is 200..203.
- `pix_ready`=0 for 10 cycles after start:
  - exactly 2 reads issued, then `rd_en` stays 0;
  - `pix_data`=200 held stable;
  - after ready rises, the stream is 200..203 with no gaps or duplicates.
- Random `pix_ready` toggling → stream order preserved and exactly 4 handshakes.
- Second start pulse in mid-frame → ignored; frame completes normally and a single `done` is seen.
- `rst` asserted after 2 handshakes → next cycle all outputs are 0 and state is IDLE; a fresh start then streams from index 0.

Source files
------------

// File: rtl/image_stream_reader_pkg.sv
// io_pkg: address-map constants and the reader FSM state type, shared by the
// IO decoder and the image stream reader.
//   ORIG_BASE / PROC_BASE : first byte address of each image region
//   IMG_PIXELS            : pixels per frame (400x400)
//   SHOW_ORIG_ADDR/_PROC  : store addresses that fire the show strobes
//   rd_state_e            : IDLE -> RUN (issuing reads) -> DRAIN (emptying)
package io_pkg;

    localparam int ORIG_BASE      = 120;
    localparam int PROC_BASE      = 160120;
    localparam int IMG_PIXELS     = 160000;
    localparam int SHOW_ORIG_ADDR = 100;
    localparam int SHOW_PROC_ADDR = 116;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/image_stream_reader_if.sv
// Memory read port plus pixel stream of the image stream reader.
//   rd_en/rd_addr -> memory, rd_data <- memory (one cycle after rd_en)
//   pix_data/pix_valid/pix_last -> display path, pix_ready <- display path
// Stream handshake: a pixel transfers on a rising clk edge where pix_valid
// and pix_ready are both high; while pix_valid is high and pix_ready low the
// source holds pix_data/pix_last stable and keeps pix_valid high.
// master = the reader, slave = memory + display side.
interface image_stream_reader_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        output rd_en, rd_addr, pix_data, pix_valid, pix_last,
        input  rd_data, pix_ready
    );

    modport slave (
        input  rd_en, rd_addr, pix_data, pix_valid, pix_last,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/image_stream_reader_skid_fifo2.sv
// skid_fifo2: two-entry first-in first-out buffer built from registers.
//   push_i/din_i  : write one entry (caller guarantees it is not full)
//   pop_i         : remove the head entry (caller guarantees not empty)
//   dout_o        : head entry, straight from the storage registers
//   valid_o       : at least one entry held
//   count_o       : number of entries held (0..2)
// Push and pop in the same cycle are both honoured.
module skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared too so the head reads 0 straight out of reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_q ^ push_i;
            rd_ptr_q <= rd_ptr_q ^ pop_i;
            count_q  <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;
endmodule

// File: rtl/image_stream_reader.sv
// image_stream_reader: on a show strobe, reads one image region out of
// memory pixel by pixel and streams it over a valid/ready handshake.
//   clk, rst                        : clock, synchronous active-high reset
//   start_original/start_processed  : show strobes (processed wins on a tie)
//   bus (master)                    : memory read port + pixel stream
//   busy                            : frame in progress
//   done                            : one-cycle pulse after last handshake
//   state_o                         : current FSM state, for observation
// A read is issued only while the FIFO entries plus the read in flight,
// less the pixel leaving this cycle, stay below 2, so the two-entry FIFO
// never overflows despite the one-cycle memory latency.
module image_stream_reader #(
    parameter int ORIG_BASE  = io_pkg::ORIG_BASE,
    parameter int PROC_BASE  = io_pkg::PROC_BASE,
    parameter int IMG_PIXELS = io_pkg::IMG_PIXELS,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_original,
    input  logic                   start_processed,
    image_stream_reader_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output io_pkg::rd_state_e      state_o
);
    import io_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_PIXELS - 1);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W:0]   head;
    logic              fifo_valid;
    logic [1:0]        fifo_count;
    logic              fifo_pop;
    logic [2:0]        committed;
    logic              issue;
    logic              issue_last;
    logic              last_pop;

    assign fifo_pop   = fifo_valid & bus.pix_ready;
    assign committed  = {1'b0, fifo_count} + {2'b00, inflight_q};
    // committed - pop < 2, rearranged to stay unsigned.
    assign issue      = (state_q == ST_RUN) && (committed < (3'd2 + {2'b00, fifo_pop}));
    assign issue_last = issue && (idx_q == LAST_IDX);
    assign last_pop   = fifo_pop & head[DATA_W];

    assign bus.rd_en   = issue;
    assign bus.rd_addr = issue ? (base_q + idx_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            idx_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            // The tag travels with the read so the FIFO knows which entry ends the frame.
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= 1'b0;
            if (issue) begin
                idx_q <= idx_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_original || start_processed) begin
                        state_q <= ST_RUN;
                        base_q  <= start_processed ? ADDR_W'(PROC_BASE) : ADDR_W'(ORIG_BASE);
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, bus.rd_data}),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign bus.pix_data  = head[DATA_W-1:0];
    assign bus.pix_valid = fifo_valid;
    assign bus.pix_last  = fifo_valid & head[DATA_W];
    assign busy          = busy_q;
    assign done          = done_q;
    assign state_o       = state_q;
endmodule
